// File: rtl/ethernet_mmio_initiator_if.sv
`default_nettype none
// =============================================================================
// Module   : ethernet_mmio_initiator_if
// Brief    : Host request/response channels plus the Ethernet MMIO slave bus.
// Revision : 1.0
// =============================================================================
interface ethernet_mmio_initiator_if #(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 14
);
   // host request channel
   logic                      req_v_i;
   logic                      req_ready_o;
   logic                      req_write_i;
   logic [addr_width_p-1:0]   req_addr_i;
   logic [data_width_p/8-1:0] req_mask_i;
   logic [data_width_p-1:0]   req_data_i;
   // host response channel
   logic                      resp_v_o;
   logic                      resp_write_o;
   logic [data_width_p-1:0]   resp_data_o;
   logic                      resp_yumi_i;
   // slave register port
   logic [addr_width_p-1:0]   addr_o;
   logic                      write_en_o;
   logic                      read_en_o;
   logic [data_width_p/8-1:0] write_mask_o;
   logic [data_width_p-1:0]   write_data_o;
   logic [data_width_p-1:0]   read_data_i;

   modport master (
      input  req_v_i, req_write_i, req_addr_i, req_mask_i, req_data_i,
      output req_ready_o,
      output resp_v_o, resp_write_o, resp_data_o,
      input  resp_yumi_i,
      output addr_o, write_en_o, read_en_o, write_mask_o, write_data_o,
      input  read_data_i
   );

   modport slave (
      output req_v_i, req_write_i, req_addr_i, req_mask_i, req_data_i,
      input  req_ready_o,
      input  resp_v_o, resp_write_o, resp_data_o,
      output resp_yumi_i,
      input  addr_o, write_en_o, read_en_o, write_mask_o, write_data_o,
      output read_data_i
   );
endinterface
`default_nettype wire

// File: rtl/ethernet_mmio_initiator.sv
`default_nettype none
// =============================================================================
// Module   : ethernet_mmio_initiator
// Brief    : Turns valid/ready host requests into single-cycle MMIO strobes and
//            returns every response in order through a credit-guarded FIFO.
// Revision : 1.0
// =============================================================================
module ethernet_mmio_initiator #(
   parameter int data_width_p = 32,
   parameter int addr_width_p = 14,
   parameter int resp_els_p   = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   ethernet_mmio_initiator_if.master bus
);
   localparam int c_mask_w = data_width_p / 8;
   localparam int c_cnt_w  = $clog2(resp_els_p + 1);
   localparam int c_ptr_w  = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;

   localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(resp_els_p);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(resp_els_p - 1);
   localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

   logic [c_cnt_w-1:0]      r_cnt;
   logic [addr_width_p-1:0] r_addr;
   logic                    r_write_en;
   logic                    r_read_en;
   logic [c_mask_w-1:0]     r_mask;
   logic [data_width_p-1:0] r_wdata;
   logic                    r_ret_v;
   logic                    r_ret_write;

   logic [data_width_p-1:0] r_fifo_data [resp_els_p];
   logic [resp_els_p-1:0]   r_fifo_write;
   logic [c_ptr_w-1:0]      r_wptr;
   logic [c_ptr_w-1:0]      r_rptr;
   logic [c_cnt_w-1:0]      r_fcnt;

   logic w_ready;
   logic w_accept;
   logic w_empty;
   logic w_pop;
   logic w_push;

   function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
      return (p == c_ptr_last) ? '0 : p + c_ptr_one;
   endfunction

   // Credits cover every stage a request can occupy, so the FIFO never overflows.
   assign w_ready  = reset_n_i & (r_cnt < c_cnt_max);
   assign w_accept = bus.req_v_i & w_ready;
   assign w_empty  = (r_fcnt == '0);
   assign w_pop    = bus.resp_yumi_i & ~w_empty;
   assign w_push   = r_ret_v;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_cnt <= '0;
      end else begin
         unique case ({w_accept, w_pop})
            2'b10:   r_cnt <= r_cnt + c_cnt_one;
            2'b01:   r_cnt <= r_cnt - c_cnt_one;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_addr     <= '0;
         r_write_en <= 1'b0;
         r_read_en  <= 1'b0;
         r_mask     <= '0;
         r_wdata    <= '0;
      end else if (w_accept) begin
         r_addr     <= bus.req_addr_i;
         r_write_en <= bus.req_write_i;
         r_read_en  <= ~bus.req_write_i;
         r_mask     <= bus.req_write_i ? bus.req_mask_i : '0;
         r_wdata    <= bus.req_write_i ? bus.req_data_i : '0;
      end else begin
         r_write_en <= 1'b0;
         r_read_en  <= 1'b0;
      end
   end

   // Return stage lines up with the cycle the slave presents read data.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_ret_v     <= 1'b0;
         r_ret_write <= 1'b0;
      end else begin
         r_ret_v     <= r_write_en | r_read_en;
         r_ret_write <= r_write_en;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_data[r_wptr]  <= r_ret_write ? '0 : bus.read_data_i;
         r_fifo_write[r_wptr] <= r_ret_write;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_next(r_wptr);
         if (w_pop)  r_rptr <= ptr_next(r_rptr);
         unique case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + c_cnt_one;
            2'b01:   r_fcnt <= r_fcnt - c_cnt_one;
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   assign bus.req_ready_o  = w_ready;
   assign bus.resp_v_o     = ~w_empty;
   assign bus.resp_write_o = ~w_empty & r_fifo_write[r_rptr];
   assign bus.resp_data_o  = w_empty ? '0 : r_fifo_data[r_rptr];

   assign bus.addr_o       = r_addr;
   assign bus.write_en_o   = r_write_en;
   assign bus.read_en_o    = r_read_en;
   assign bus.write_mask_o = r_mask;
   assign bus.write_data_o = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_ethernet_mmio_initiator.sv
`default_nettype none
// =============================================================================
// Module   : tb_ethernet_mmio_initiator
// Brief    : Randomized scoreboard bench with a register-file reference model.
// Revision : 1.0
// =============================================================================
module tb_ethernet_mmio_initiator;
   localparam int c_dw  = 32;
   localparam int c_aw  = 14;
   localparam int c_els = 4;
   localparam int c_mw  = c_dw / 8;

   typedef struct {
      logic [c_aw-1:0] addr;
      logic            we;
      logic            re;
      logic [c_mw-1:0] mask;
      logic [c_dw-1:0] data;
      int              cyc;
   } strobe_t;

   typedef struct {
      logic            write;
      logic [c_dw-1:0] data;
      int              cyc;
   } resp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic yumi_en = 1'b0;
   logic yumi_rand = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   strobe_t exp_strobe[$];
   resp_t   exp_resp[$];
   int      acc_cycles[$];
   int      pop_cycles[$];
   int      pool[8];
   logic [c_dw-1:0] ref_mem [int];
   logic [c_dw-1:0] slv_mem [int];
   strobe_t mon_s;
   resp_t   mon_r;

   ethernet_mmio_initiator_if #(.data_width_p(c_dw), .addr_width_p(c_aw)) bus();

   ethernet_mmio_initiator #(
      .data_width_p(c_dw),
      .addr_width_p(c_aw),
      .resp_els_p  (c_els)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.resp_yumi_i = yumi_en & bus.resp_v_o;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- reference register file ----------------
   function automatic logic [c_dw-1:0] init_val(input int a);
      logic [31:0] v;
      v = a;
      return (v * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [c_dw-1:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic void ref_write(input int a, input logic [c_mw-1:0] m, input logic [c_dw-1:0] d);
      logic [c_dw-1:0] v;
      v = ref_read(a);
      for (int b = 0; b < c_mw; b++)
         if (m[b]) v[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = v;
   endfunction

   // ---------------- slave device model (synchronous register file) ----------------
   function automatic logic [c_dw-1:0] slv_read(input int a);
      return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
   endfunction

   always @(posedge clk) begin
      logic [c_dw-1:0] bm;
      if (bus.write_en_o) begin
         for (int b = 0; b < c_mw; b++) bm[8*b +: 8] = {8{bus.write_mask_o[b]}};
         slv_mem[int'(bus.addr_o)] = (slv_read(int'(bus.addr_o)) & ~bm) | (bus.write_data_o & bm);
      end
      if (bus.read_en_o) bus.read_data_i <= slv_read(int'(bus.addr_o));
      else               bus.read_data_i <= $urandom;
   end

   // ---------------- random consumer ----------------
   initial forever begin
      @(posedge clk);
      #1;
      if (yumi_rand) yumi_en = 1'($urandom_range(0, 1));
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.write_en_o || bus.read_en_o) begin
            check("strobe_exclusive", {63'd0, bus.write_en_o & bus.read_en_o}, 64'd0);
            if (exp_strobe.size() == 0) begin
               fail("unexpected_strobe");
            end else begin
               mon_s = exp_strobe.pop_front();
               check("strobe_fields",
                     {12'd0, bus.addr_o, bus.write_en_o, bus.read_en_o, bus.write_mask_o, bus.write_data_o},
                     {12'd0, mon_s.addr, mon_s.we, mon_s.re, mon_s.mask, mon_s.data});
               check("strobe_cycle", 64'(cyc), 64'(mon_s.cyc));
            end
         end else if (exp_strobe.size() != 0 && exp_strobe[0].cyc <= cyc) begin
            void'(exp_strobe.pop_front());
            fail("missing_strobe");
         end

         if (bus.resp_v_o) begin
            if (exp_resp.size() == 0) begin
               fail("stale_response");
            end else if (bus.resp_yumi_i) begin
               mon_r = exp_resp.pop_front();
               check("resp_fields", {31'd0, bus.resp_write_o, bus.resp_data_o}, {31'd0, mon_r.write, mon_r.data});
               check("resp_latency", {63'd0, cyc >= mon_r.cyc}, 64'd1);
               pop_cycles.push_back(cyc);
            end
         end

         if (bus.req_v_i && bus.req_ready_o) begin
            mon_s.addr = bus.req_addr_i;
            mon_s.we   = bus.req_write_i;
            mon_s.re   = ~bus.req_write_i;
            mon_s.mask = bus.req_write_i ? bus.req_mask_i : '0;
            mon_s.data = bus.req_write_i ? bus.req_data_i : '0;
            mon_s.cyc  = cyc + 1;
            exp_strobe.push_back(mon_s);
            mon_r.write = bus.req_write_i;
            mon_r.data  = bus.req_write_i ? '0 : ref_read(int'(bus.req_addr_i));
            mon_r.cyc   = cyc + 3;
            exp_resp.push_back(mon_r);
            if (bus.req_write_i) ref_write(int'(bus.req_addr_i), bus.req_mask_i, bus.req_data_i);
            acc_cycles.push_back(cyc);
         end
      end
   end

   // ---------------- stimulus tasks (entered and left at posedge + 1) ----------------
   task automatic set_fields(input logic w, input logic [c_aw-1:0] a, input logic [c_mw-1:0] m, input logic [c_dw-1:0] d);
      bus.req_write_i = w;
      bus.req_addr_i  = a;
      bus.req_mask_i  = m;
      bus.req_data_i  = d;
   endtask

   task automatic rand_fields();
      set_fields(1'($urandom_range(0, 1)), c_aw'(pool[$urandom_range(0, 7)]), c_mw'($urandom), $urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic w, input logic [c_aw-1:0] a, input logic [c_mw-1:0] m, input logic [c_dw-1:0] d);
      int n;
      n = 0;
      set_fields(w, a, m, d);
      bus.req_v_i = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.req_ready_o) break;
         n++;
         if (n > 500) begin
            fail("request_timeout");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.req_v_i = 1'b0;
   endtask

   task automatic hold_valid(input int n);
      logic acc;
      repeat (n) begin
         @(negedge clk);
         acc = bus.req_ready_o;
         @(posedge clk);
         #1;
         if (acc) rand_fields();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      yumi_en = 1'b1;
      while ((exp_resp.size() != 0 || exp_strobe.size() != 0) && n < 200) begin
         idle(1);
         n++;
      end
      check("drain_empty", 64'(exp_resp.size()), 64'd0);
      idle(2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.req_v_i = 1'b0;
      set_fields(1'b0, '0, '0, '0);
      pool[0] = 32'h0010;
      pool[1] = 32'h1004;
      for (int i = 2; i < 8; i++) pool[i] = $urandom_range(0, (1 << c_aw) - 1);
      ref_mem[32'h1004] = 32'h1234_5678;
      slv_mem[32'h1004] = 32'h1234_5678;

      // reset values
      #3 reset_n = 1'b0;
      #1;
      check("rst_req_ready", {63'd0, bus.req_ready_o}, 64'd0);
      check("rst_resp_v",    {63'd0, bus.resp_v_o},    64'd0);
      check("rst_strobes",   {62'd0, bus.write_en_o, bus.read_en_o}, 64'd0);
      check("rst_addr",      64'(bus.addr_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {63'd0, bus.req_ready_o}, 64'd1);
      check("post_rst_resp_v", {63'd0, bus.resp_v_o}, 64'd0);
      @(posedge clk);
      #1;

      // single write
      yumi_en = 1'b1;
      issue(1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF);
      @(negedge clk);
      check("wr_strobe", {63'd0, bus.write_en_o}, 64'd1);
      check("wr_addr", 64'(bus.addr_o), 64'h0010);
      check("wr_mask_data", {28'd0, bus.write_mask_o, bus.write_data_o}, {28'd0, 4'hF, 32'hDEAD_BEEF});
      @(negedge clk);
      check("wr_strobe_drop", {63'd0, bus.write_en_o}, 64'd0);
      @(negedge clk);
      check("wr_resp", {61'd0, bus.resp_v_o, bus.resp_write_o, |bus.resp_data_o}, {61'd0, 3'b110});
      idle(3);

      // single read
      issue(1'b0, 14'h1004, 4'hF, 32'hFFFF_FFFF);
      @(negedge clk);
      check("rd_strobe", {62'd0, bus.read_en_o, bus.write_en_o}, 64'd2);
      check("rd_mask", 64'(bus.write_mask_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("rd_resp_v", {63'd0, bus.resp_v_o}, 64'd1);
      check("rd_resp", {31'd0, bus.resp_write_o, bus.resp_data_o}, {31'd0, 1'b0, 32'h1234_5678});
      idle(3);

      // streaming with yumi held high
      acc_cycles.delete();
      pop_cycles.delete();
      for (int i = 0; i < 8; i++)
         issue(1'(i % 2), c_aw'(pool[$urandom_range(0, 7)]), c_mw'($urandom), $urandom);
      drain();
      check("stream_accepts", 64'(acc_cycles.size()), 64'd8);
      check("stream_pops", 64'(pop_cycles.size()), 64'd8);
      if (acc_cycles.size() == 8 && pop_cycles.size() == 8) begin
         for (int i = 1; i < 8; i++) begin
            check("stream_accept_gap", 64'(acc_cycles[i] - acc_cycles[i-1]), 64'd1);
            check("stream_pop_gap", 64'(pop_cycles[i] - pop_cycles[i-1]), 64'd1);
         end
         check("stream_first_resp", 64'(pop_cycles[0] - acc_cycles[0]), 64'd3);
      end

      // backpressure
      yumi_en = 1'b0;
      acc_cycles.delete();
      rand_fields();
      bus.req_v_i = 1'b1;
      hold_valid(8);
      check("bp_accepts", 64'(acc_cycles.size()), 64'(c_els));
      @(negedge clk);
      check("bp_ready_low", {63'd0, bus.req_ready_o}, 64'd0);
      @(posedge clk);
      #1 yumi_en = 1'b1;
      @(posedge clk);
      #1 yumi_en = 1'b0;
      @(negedge clk);
      check("bp_ready_after_yumi", {63'd0, bus.req_ready_o}, 64'd1);
      @(posedge clk);
      #1 rand_fields();
      hold_valid(6);
      @(negedge clk);
      check("bp_ready_low_again", {63'd0, bus.req_ready_o}, 64'd0);
      @(posedge clk);
      #1 bus.req_v_i = 1'b0;
      check("bp_total_accepts", 64'(acc_cycles.size()), 64'(c_els + 1));
      drain();

      // simultaneous accept and yumi at cnt = els-1
      yumi_en = 1'b0;
      for (int i = 0; i < c_els - 1; i++)
         issue(1'(i % 2), c_aw'(pool[$urandom_range(0, 7)]), c_mw'($urandom), $urandom);
      idle(4);
      rand_fields();
      bus.req_v_i = 1'b1;
      yumi_en = 1'b1;
      @(negedge clk);
      check("sim_ready_pre", {62'd0, bus.req_ready_o, bus.resp_yumi_i}, 64'd3);
      @(posedge clk);
      #1 yumi_en = 1'b0;
      rand_fields();
      @(negedge clk);
      check("sim_cnt_hold", {63'd0, bus.req_ready_o}, 64'd1);
      @(posedge clk);
      #1 bus.req_v_i = 1'b0;
      @(negedge clk);
      check("sim_full", {63'd0, bus.req_ready_o}, 64'd0);
      @(posedge clk);
      #1;
      drain();

      // randomized traffic with a random consumer
      yumi_rand = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else issue(1'($urandom_range(0, 1)), c_aw'(pool[$urandom_range(0, 7)]), c_mw'($urandom), $urandom);
      end
      yumi_rand = 1'b0;
      idle(1);
      drain();

      // reset while a read strobe is high and two responses are queued
      yumi_en = 1'b0;
      issue(1'b1, c_aw'(pool[2]), 4'hF, $urandom);
      issue(1'b1, c_aw'(pool[3]), 4'h5, $urandom);
      idle(3);
      issue(1'b0, c_aw'(pool[4]), 4'h0, 32'd0);
      check("mid_read_strobe", {63'd0, bus.read_en_o}, 64'd1);
      check("mid_resp_queued", {63'd0, bus.resp_v_o}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ready", {63'd0, bus.req_ready_o}, 64'd0);
      check("mid_rst_resp", {62'd0, bus.resp_v_o, bus.resp_write_o}, 64'd0);
      check("mid_rst_resp_data", 64'(bus.resp_data_o), 64'd0);
      check("mid_rst_strobes", {62'd0, bus.write_en_o, bus.read_en_o}, 64'd0);
      check("mid_rst_bus", {14'd0, bus.addr_o, bus.write_mask_o, bus.write_data_o}, 64'd0);
      exp_strobe.delete();
      exp_resp.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("mid_post_ready", {63'd0, bus.req_ready_o}, 64'd1);
      check("mid_post_resp_v", {63'd0, bus.resp_v_o}, 64'd0);
      @(posedge clk);
      #1 yumi_en = 1'b1;
      idle(6);
      issue(1'b0, c_aw'(pool[2]), 4'h0, 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
